// File: rtl/warp_scheduler.sv
// Per-core warp issue arbiter: tracks the active/exited warps of a block and picks one
// ready warp per issue slot (round-robin or greedy-then-oldest with starvation forcing).
module warp_scheduler #(
    parameter int WARPS_PER_CORE = 4,
    parameter int POLICY         = 0,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [$clog2(WARPS_PER_CORE+1)-1:0] num_warps,
    input  logic [WARPS_PER_CORE-1:0]           warp_ready,
    input  logic [WARPS_PER_CORE-1:0]           warp_exit,
    input  logic                                issue_ready,
    output logic                                issue_valid,
    output logic [$clog2(WARPS_PER_CORE)-1:0]   issue_warp,
    output logic [WARPS_PER_CORE-1:0]           active_mask,
    output logic                                done
);
    localparam int W  = WARPS_PER_CORE;
    localparam int IW = $clog2(WARPS_PER_CORE);
    localparam int NW = $clog2(WARPS_PER_CORE + 1);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   warp_q, warp_d;
    logic [IW-1:0]   last_q, last_d;
    logic            lastv_q, lastv_d;
    logic [W-1:0]    active_q, active_d;
    logic [W-1:0]    exited_q, exited_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q [W];
    logic [CW-1:0]   cnt_d [W];

    logic [W-1:0]    start_mask_s;
    logic [W-1:0]    exit_eff_s;
    logic [W-1:0]    eligible_s;
    logic [W-1:0]    starve_s;
    logic            handshake_s;
    logic [IW-1:0]   rr_win_s, low_starve_s, low_elig_s, gto_win_s, winner_s;

    assign exit_eff_s  = warp_exit & active_q;
    assign eligible_s  = warp_ready & active_q & ~exited_q;
    assign handshake_s = valid_q & issue_ready;

    // Block mask from num_warps; counts above the warp count saturate to all warps
    always_comb begin
        for (int i = 0; i < W; i++) begin
            start_mask_s[i] = (NW'(i) < num_warps);
            starve_s[i]     = eligible_s[i] & (cnt_q[i] >= CW'(STARVE_LIMIT));
        end
    end

    // Candidate winners; downward scans let the lowest matching index overwrite last
    always_comb begin
        rr_win_s     = '0;
        low_starve_s = '0;
        low_elig_s   = '0;
        for (int k = W; k >= 1; k--) begin
            rr_win_s = eligible_s[IW'((int'(last_q) + k) % W)] ?
                       IW'((int'(last_q) + k) % W) : rr_win_s;
        end
        for (int i = W - 1; i >= 0; i--) begin
            low_starve_s = starve_s[i]   ? IW'(i) : low_starve_s;
            low_elig_s   = eligible_s[i] ? IW'(i) : low_elig_s;
        end
        // Greedy stickiness only applies once a warp has actually issued in this block
        gto_win_s = (starve_s != '0) ? low_starve_s :
                    (lastv_q && eligible_s[last_q]) ? last_q : low_elig_s;
        winner_s  = (POLICY == 1) ? gto_win_s : rr_win_s;
    end

    // Next-state logic for the block FSM, issue slot and starvation counters
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        warp_d   = warp_q;
        last_d   = last_q;
        lastv_d  = lastv_q;
        active_d = active_q;
        exited_d = exited_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                valid_d = 1'b0;
                if (start) begin
                    active_d = start_mask_s;
                    exited_d = '0;
                    last_d   = IW'(W - 1);
                    lastv_d  = 1'b0;
                    for (int i = 0; i < W; i++) begin
                        cnt_d[i] = '0;
                    end
                    done_d  = (start_mask_s == '0);
                    state_d = (start_mask_s == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                exited_d = exited_q | exit_eff_s;
                if ((active_q & ~(exited_q | exit_eff_s)) == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                end else if (valid_q) begin
                    if (handshake_s) begin
                        valid_d = 1'b0;
                        last_d  = warp_q;
                        lastv_d = 1'b1;
                    end else if (exit_eff_s[warp_q]) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                    end
                end else if (eligible_s != '0) begin
                    valid_d = 1'b1;
                    warp_d  = winner_s;
                    for (int i = 0; i < W; i++) begin
                        cnt_d[i] = (IW'(i) == winner_s) ? CW'(0) :
                                   !eligible_s[i] ? cnt_q[i] :
                                   (cnt_q[i] >= CW'(STARVE_LIMIT)) ? CW'(STARVE_LIMIT) :
                                   cnt_q[i] + CW'(1);
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            warp_q   <= '0;
            last_q   <= IW'(W - 1);
            lastv_q  <= 1'b0;
            active_q <= '0;
            exited_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            warp_q   <= warp_d;
            last_q   <= last_d;
            lastv_q  <= lastv_d;
            active_q <= active_d;
            exited_q <= exited_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign issue_valid = valid_q;
    assign issue_warp  = warp_q;
    assign active_mask = active_q;
    assign done        = done_q;
endmodule
